battousai_store: RTL and testbench

- Write-side counterpart of the load data path. Executes RISC-V stores (sb/sh/sw/sd, opcode 7'd35) against a 64-bit, doubleword-addressed data memory.
- Sub-doubleword stores use read-modify-write: fetch the doubleword, merge the store bytes into their lanes, write it back.
- Sits between the multicycle control unit (start/done handshake) and the data memory port.

---
 rtl/battousai_pkg.sv | 20 ++
 rtl/battousai_store_if.sv | 26 ++
 rtl/battousai_store_merge.sv | 24 ++
 rtl/battousai_store.sv | 75 +++++++
 tb/tb_battousai_store.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/battousai_pkg.sv
// battousai_pkg: shared opcode/funct3 constants, store FSM states, access widths and store legality check
// Ports: none (package)
package battousai_pkg;
    localparam logic [6:0] OPC_STORE = 7'd35;
    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;
    localparam logic [2:0] F3_SD = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} store_state_t;

    typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD, W_DOUBLE} width_t;

    function automatic logic store_legal(input logic [2:0] f3, input logic [2:0] off);
        return f3 == F3_SB ? 1'b1 :
               f3 == F3_SH ? ~off[0] :
               f3 == F3_SW ? off[1:0] == 2'b00 :
               f3 == F3_SD ? off == 3'b000 : 1'b0;
    endfunction
endpackage

// File: rtl/battousai_store_if.sv
// battousai_store_if: control handshake plus data memory port of the store unit
// Ports: start/instruction/address/data and mem_rdata flow master->slave; mem_* strobes, busy, done, store_error flow slave->master
interface battousai_store_if;
    logic        start;
    logic [31:0] Register_Intruction_Instr31_0;
    logic [63:0] store_addr;
    logic [63:0] store_data;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        store_error;

    modport master (
        output start, Register_Intruction_Instr31_0, store_addr, store_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, store_error
    );

    modport slave (
        input  start, Register_Intruction_Instr31_0, store_addr, store_data, mem_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, store_error
    );
endinterface

// File: rtl/battousai_store_merge.sv
// battousai_store_merge: merges store bytes into their lanes of a fetched doubleword
// Ports: rdata (fetched doubleword), wdata (store value, low bytes used), off (byte offset), funct3 (width), merged (result)
module battousai_store_merge
    import battousai_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] merged
);
    width_t      w;
    logic [3:0]  n;
    logic [3:0]  lo;
    logic [63:0] sh;
    assign w  = width_t'(funct3[1:0]);
    // illegal widths replace no bytes
    assign n  = funct3[2] ? 4'd0 : 4'd1 << w;
    assign lo = {1'b0, off};
    assign sh = wdata << {off, 3'b000};
    for (genvar k = 0; k < 8; k++) begin : g_b
        assign merged[8*k +: 8] = (4'(k) >= lo && 4'(k) < lo + n) ? sh[8*k +: 8] : rdata[8*k +: 8];
    end
endmodule

// File: rtl/battousai_store.sv
// battousai_store: RISC-V sb/sh/sw/sd executor doing read-modify-write on a 64-bit doubleword memory
// Ports: clk, reset (asynchronous, active-high); bus (slave) carries the start/done handshake and the data memory port
module battousai_store
    import battousai_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input logic              clk,
    input logic              reset,
    battousai_store_if.slave bus
);
    store_state_t state, nxt;
    logic [2:0]   f3, cnt;
    logic [63:0]  addr, data, wd, merged;
    logic         err, req, legal;

    assign req   = state == S_IDLE && bus.start && bus.Register_Intruction_Instr31_0[6:0] == OPC_STORE;
    assign legal = store_legal(bus.Register_Intruction_Instr31_0[14:12], bus.store_addr[2:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (req) nxt = !legal ? S_DONE :
                                    bus.Register_Intruction_Instr31_0[14:12] == F3_SD ? S_WRITE : S_READ;
            S_READ:  nxt = S_WAIT;
            S_WAIT:  if (cnt == 3'd0) nxt = S_WRITE;
            S_WRITE: nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    // wd holds store_data for sd and is overwritten by the merge result for narrower stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3   <= '0;
            cnt  <= '0;
            addr <= '0;
            data <= '0;
            wd   <= '0;
            err  <= 1'b0;
        end else begin
            if (req) begin
                f3   <= bus.Register_Intruction_Instr31_0[14:12];
                addr <= bus.store_addr;
                data <= bus.store_data;
                wd   <= bus.store_data;
                err  <= !legal;
            end
            if (state == S_READ) cnt <= 3'(MEM_LATENCY - 1);
            else if (state == S_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
            if (state == S_WAIT && cnt == 3'd0) wd <= merged;
        end
    end

    battousai_store_merge u_merge (
        .rdata (bus.mem_rdata),
        .wdata (data),
        .off   (addr[2:0]),
        .funct3(f3),
        .merged(merged)
    );

    assign bus.busy        = state != S_IDLE;
    assign bus.done        = state == S_DONE;
    assign bus.store_error = state == S_DONE && err;
    assign bus.mem_rd      = state == S_READ;
    assign bus.mem_wr      = state == S_WRITE;
    assign bus.mem_addr    = state inside {S_READ, S_WAIT, S_WRITE} ? {addr[63:3], 3'b000} : 64'd0;
    assign bus.mem_wdata   = state == S_WRITE ? wd : 64'd0;
endmodule

// File: tb/tb_battousai_store.sv
// tb_battousai_store: randomized and directed stores against two latencies with a cycle-level expectation model
module tb_battousai_store;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] saddr = '0;
    logic [63:0] sdata = '0;

    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    // current transaction as the model sees it
    int          t0 = 0;
    bit          act = 1'b0;
    int          kind = 0;
    logic [63:0] ea = '0;
    logic [63:0] ewd [2];

    logic [63:0] mem [2][16];
    int          dcyc [2];
    int          nrd [2];
    int          nwr [2];
    logic [63:0] lwd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input int g, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s dut%0d cycle %0d got %h want %h", n, g, cyc, a, e);
        end
    endtask

    function automatic logic [63:0] mmerge(input logic [63:0] old, input logic [63:0] d, input int off, input int nb);
        logic [63:0] r = old;
        for (int k = 0; k < nb; k++) r[8*(off+k) +: 8] = d[8*k +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int L = g == 0 ? 1 : 3;
        battousai_store_if bus ();
        logic [63:0] rdv = '0;
        logic [7:0]  pipe = '0;
        logic [63:0] ra = '0;
        bit          rds, wrs;

        assign bus.start = start;
        assign bus.Register_Intruction_Instr31_0 = instr;
        assign bus.store_addr = saddr;
        assign bus.store_data = sdata;
        assign bus.mem_rdata = rdv;

        battousai_store #(.MEM_LATENCY(L)) u_dut (.clk(clk), .reset(rst), .bus(bus));

        // memory: read data is valid only in the single cycle L cycles after the read strobe
        always begin
            @(negedge clk);
            rds = bus.mem_rd;
            wrs = bus.mem_wr;
            if (rds) begin
                ra = bus.mem_addr;
                nrd[g]++;
            end
            if (wrs) begin
                mem[g][bus.mem_addr[6:3]] = bus.mem_wdata;
                lwd[g] = bus.mem_wdata;
                nwr[g]++;
            end
            if (bus.done) dcyc[g] = cyc - t0;
            @(posedge clk);
            #1;
            pipe = rst ? 8'd0 : {pipe[6:0], rds};
            rdv = pipe[L-1] ? mem[g][ra[6:3]] : {$urandom, $urandom};
        end

        always @(negedge clk) begin : cmp
            int c;
            bit rd, wt, wr, dn, bz;
            c  = cyc - t0;
            rd = act && kind == 3 && c == 1;
            wt = act && kind == 3 && c >= 2 && c <= L + 1;
            wr = act && (kind == 2 && c == 1 || kind == 3 && c == L + 2);
            dn = act && (kind == 1 && c == 1 || kind == 2 && c == 2 || kind == 3 && c == L + 3);
            bz = act && kind != 0 && c >= 1 && c <= (kind == 3 ? L + 3 : kind);
            chk("busy", g, 64'(bus.busy), 64'(bz));
            chk("done", g, 64'(bus.done), 64'(dn));
            chk("store_error", g, 64'(bus.store_error), 64'(dn && kind == 1));
            chk("mem_rd", g, 64'(bus.mem_rd), 64'(rd));
            chk("mem_wr", g, 64'(bus.mem_wr), 64'(wr));
            chk("mem_addr", g, bus.mem_addr, (rd || wt || wr) ? {ea[63:3], 3'b000} : 64'd0);
            chk("mem_wdata", g, bus.mem_wdata, wr ? ewd[g] : 64'd0);
        end
    end

    task automatic preload(input logic [63:0] a, input logic [63:0] v);
        mem[0][a[6:3]] = v;
        mem[1][a[6:3]] = v;
    endtask

    // called at a falling edge; start is high during cycle 0, the cycles after it are 1..n
    task automatic do_store(input logic [2:0] f3, input logic [6:0] op, input logic [63:0] a,
                            input logic [63:0] d, input bit junk, input int rstc);
        logic [31:0] ins;
        int          k, n;
        bit          legal;
        ins = $urandom;
        ins[14:12] = f3;
        ins[6:0] = op;
        instr = ins;
        saddr = a;
        sdata = d;
        start = 1'b1;
        legal = f3 < 3'd4 && (int'(a[2:0]) % (1 << int'(f3))) == 0;
        k = op != 7'd35 ? 0 : !legal ? 1 : f3 == 3'd3 ? 2 : 3;
        for (int g = 0; g < 2; g++) begin
            ewd[g] = k == 3 ? mmerge(mem[g][a[6:3]], d, int'(a[2:0]), 1 << int'(f3)) : d;
            dcyc[g] = -1;
            nrd[g] = 0;
            nwr[g] = 0;
            lwd[g] = '0;
        end
        kind = k;
        ea = a;
        t0 = cyc;
        act = 1'b1;
        n = (k == 3 ? 6 : k) + 1 + $urandom_range(0, 2);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start = junk && k != 0 && c == 1;
            if (start) begin
                ins = $urandom;
                ins[6:0] = 7'd35;
                instr = ins;
                saddr = {$urandom, $urandom};
                sdata = {$urandom, $urandom};
            end
            if (k == 3 && rstc == c) begin
                #1;
                rst = 1'b1;
                act = 1'b0;
            end
            if (k == 3 && rstc != 0 && c == rstc + 1) rst = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        for (int i = 0; i < 16; i++) preload(64'(i) << 3, {$urandom, $urandom});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        preload(64'h1000, 64'h1122334455667788);
        do_store(3'd0, 7'd35, 64'h1003, 64'hAB, 1'b0, 0);
        chk("sb_wdata", 0, lwd[0], 64'h11223344AB667788);
        chk("sb_done_cycle", 0, 64'(dcyc[0]), 64'd4);
        chk("sb_done_cycle", 1, 64'(dcyc[1]), 64'd6);

        preload(64'h2004, 64'h0123456789ABCDEF);
        do_store(3'd2, 7'd35, 64'h2004, 64'hFFFF0000DEADBEEF, 1'b0, 0);
        chk("sw_wdata", 0, lwd[0], 64'hDEADBEEF89ABCDEF);
        chk("sw_rd_pulses", 0, 64'(nrd[0]), 64'd1);
        chk("sw_wr_pulses", 0, 64'(nwr[0]), 64'd1);

        do_store(3'd3, 7'd35, 64'h3000, 64'hCAFEF00DCAFEF00D, 1'b0, 0);
        chk("sd_rd_pulses", 0, 64'(nrd[0]), 64'd0);
        chk("sd_done_cycle", 0, 64'(dcyc[0]), 64'd2);
        chk("sd_wdata", 1, lwd[1], 64'hCAFEF00DCAFEF00D);

        do_store(3'd1, 7'd35, 64'h4001, 64'h5555, 1'b0, 0);
        chk("mis_done_cycle", 0, 64'(dcyc[0]), 64'd1);
        chk("mis_wr_pulses", 0, 64'(nwr[0]), 64'd0);
        chk("mis_rd_pulses", 1, 64'(nrd[1]), 64'd0);

        do_store(3'd5, 7'd35, 64'h4000, 64'h7777, 1'b0, 0);
        chk("f3_5_done_cycle", 1, 64'(dcyc[1]), 64'd1);
        chk("f3_5_wr_pulses", 1, 64'(nwr[1]), 64'd0);

        preload(64'h5006, 64'h00FFEEDDCCBBAA99);
        do_store(3'd1, 7'd35, 64'h5006, 64'h1234, 1'b0, 0);
        chk("sh_lat3_wdata", 1, lwd[1], 64'h1234EEDDCCBBAA99);
        chk("sh_lat3_done_cycle", 1, 64'(dcyc[1]), 64'd6);

        do_store(3'd2, 7'd3, 64'h6000, 64'h1, 1'b0, 0);
        chk("load_op_done", 0, 64'(dcyc[0]), 64'hFFFFFFFFFFFFFFFF);
        chk("load_op_rd_pulses", 1, 64'(nrd[1]), 64'd0);

        do_store(3'd0, 7'd35, 64'h7002, 64'h99, 1'b1, 0);
        chk("busy_start_wr_pulses", 1, 64'(nwr[1]), 64'd1);

        do_store(3'd1, 7'd35, 64'h1002, 64'hBEEF, 1'b0, 2);
        chk("reset_wr_pulses", 0, 64'(nwr[0]), 64'd0);
        chk("reset_done", 1, 64'(dcyc[1]), 64'hFFFFFFFFFFFFFFFF);

        repeat (250) begin
            f3 = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a[2:0] = a[2:0] & ~3'((1 << int'(f3[1:0])) - 1);
            do_store(f3, $urandom_range(0, 9) == 0 ? 7'd3 : 7'd35, a, {$urandom, $urandom},
                     1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0 ? 2 : 0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
